// File: rtl/branch_predictor_pkg.sv
// Shared types, counter encodings and helpers for the dynamic branch predictor.
package bp_pkg;

    localparam int unsigned BP_TAG_W = 8;
    localparam int unsigned BP_CNT_W = 2;

    localparam logic [BP_CNT_W-1:0] CNT_SNT = '0;
    localparam logic [BP_CNT_W-1:0] CNT_WT  = {1'b1, {(BP_CNT_W-1){1'b0}}};
    localparam logic [BP_CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;
    localparam logic [BP_CNT_W-1:0] CNT_ST  = '1;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [BP_CNT_W-1:0] cnt;
    } btb_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [BP_CNT_W-1:0] sat_update(input logic [BP_CNT_W-1:0] cnt,
                                                       input logic up);
        if (up)
            return (cnt == CNT_ST) ? cnt : cnt + 1'b1;
        else
            return (cnt == CNT_SNT) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: one async lookup port, one synchronous read-modify-write update port.
module btb_array
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic [BP_TAG_W-1:0] rd_tag,
    output logic [31:0]         rd_target,
    output logic                rd_taken,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_branch,
    input  logic                upd_taken,
    input  logic [BP_TAG_W-1:0] upd_tag,
    input  logic [31:0]         upd_target
);

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];
    btb_entry_t cur;
    btb_entry_t nxt;

    assign rd_valid  = mem_q[rd_idx].valid;
    assign rd_tag    = mem_q[rd_idx].tag;
    assign rd_target = mem_q[rd_idx].target;
    assign rd_taken  = mem_q[rd_idx].cnt[BP_CNT_W-1];

    // A non-branch update means the entry aliased onto a non-branch: drop it.
    always_comb begin
        cur = mem_q[upd_idx];
        nxt = cur;
        if (upd_branch) begin
            nxt.cnt = sat_update(cur.cnt, upd_taken);
            if (upd_taken && (!cur.valid || cur.tag != upd_tag || cur.target != upd_target)) begin
                nxt.valid  = 1'b1;
                nxt.tag    = upd_tag;
                nxt.target = upd_target;
                nxt.cnt    = CNT_WT;
            end
        end else begin
            nxt.valid = 1'b0;
        end
        mem_d = mem_q;
        if (upd_en)
            mem_d[upd_idx] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i].valid  <= 1'b0;
                mem_q[i].tag    <= '0;
                mem_q[i].target <= '0;
                mem_q[i].cnt    <= CNT_WNT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF lookup, IF->ID prediction copy, ID check and table update.
// Define BP_GSHARE_EN to XOR global branch history into the BTB index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = BP_TAG_W,
    parameter int unsigned CNT_W   = BP_CNT_W,
    parameter int unsigned GHR_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        ClearD,
    input  logic        BranchD,
    input  logic        BrTrueD,
    input  logic [31:0] PCBranchD,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    output logic        MispredictD,
    output logic [31:0] RedirectPCD
);

    localparam int unsigned IDX_W = idx_width(ENTRIES);

    // Entry field widths are fixed by btb_entry_t in the package.
    if (TAG_W != BP_TAG_W || CNT_W != BP_CNT_W || GHR_W > IDX_W) begin : g_param_check
        $error("branch_predictor: unsupported parameter combination");
    end

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic             rd_taken;

    logic [31:0]      pcd_q, pcd_d;
    logic             pred_taken_q, pred_taken_d;
    logic [31:0]      pred_target_q, pred_target_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             upd_en;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign idx_f = PCF[IDX_W+1:2] ^ IDX_W'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (!StallD && BranchD)
            ghr_d = GHR_W'({ghr_q, BrTrueD});
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end
`else
    assign idx_f = PCF[IDX_W+1:2];
`endif

    assign tag_f       = PCF[IDX_W+2 +: TAG_W];
    assign PredTakenF  = rd_valid && (rd_tag == tag_f) && rd_taken;
    assign PredTargetF = PredTakenF ? rd_target : PCF + 32'd4;

    always_comb begin
        pcd_d         = pcd_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        idx_d         = idx_q;
        if (ClearD) begin
            pcd_d         = '0;
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
            idx_d         = '0;
        end else if (!StallD) begin
            pcd_d         = PCF;
            pred_taken_d  = PredTakenF;
            pred_target_d = PredTargetF;
            idx_d         = idx_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcd_q         <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            idx_q         <= '0;
        end else begin
            pcd_q         <= pcd_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            idx_q         <= idx_d;
        end
    end

    assign MispredictD = BranchD ? ((pred_taken_q != BrTrueD) ||
                                    (BrTrueD && (pred_target_q != PCBranchD)))
                                 : pred_taken_q;
    assign RedirectPCD = (BranchD && BrTrueD) ? PCBranchD : pcd_q + 32'd4;
    assign upd_en      = !StallD && (BranchD || pred_taken_q);

    btb_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (idx_f),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_taken   (rd_taken),
        .upd_en     (upd_en),
        .upd_idx    (idx_q),
        .upd_branch (BranchD),
        .upd_taken  (BrTrueD),
        .upd_tag    (pcd_q[IDX_W+2 +: TAG_W]),
        .upd_target (PCBranchD)
    );

endmodule
